openofdm_rx_ctrl: RTL
=====================

// Module: openofdm_rx_ctrl
// PURPOSE
//  Sequencer/watchdog for the dot11 receive pipeline. Drives dot11.enable and a soft-reset pulse.
//  Tracks preamble -> SIGNAL -> FCS progress. Aborts stalled or false-triggered receptions on
//  sample-count timeouts and blanks the receiver while the local transmitter is active.
//  Sits between the register bank (set_stb/set_addr/set_data) and the dot11 instance.
// PARAMETERS
//  TMO_W        16   width of timeout/holdoff counters (counts sample strobes)
//  RST_CYCLES   4    soft-reset pulse length in clock cycles (>=1)
//  CNT_W        32   width of statistics counters
// PORTS
//  clock                    in   1      clock
//  reset                    in   1      synchronous, active-high
//  enable                   in   1      global enable; 0 forces IDLE, rx_enable=0
//  set_stb                  in   1      config write strobe
//  set_addr                 in   8      config address
//  set_data                 in   32     config data
//  sample_in_strobe         in   1      one pulse per baseband sample; timeout time base
//  tx_busy                  in   1      local TX active (level)
//  short_preamble_detected  in   1      from dot11
//  long_preamble_detected   in   1      from dot11
//  legacy_sig_stb           in   1      from dot11, SIGNAL field decoded
//  fcs_out_strobe           in   1      from dot11, end of PSDU
//  fcs_ok                   in   1      valid with fcs_out_strobe
//  rx_enable                out  1      to dot11.enable
//  rx_soft_reset            out  1      OR-ed into dot11.reset
//  ctrl_state               out  3      current FSM state
//  pkt_done_stb             out  1      1-cycle pulse, packet finished (ok or bad FCS)
//  pkt_abort_stb            out  1      1-cycle pulse, reception aborted (timeout or TX)
//  pkt_ok_cnt, pkt_bad_cnt, pkt_tmo_cnt  out CNT_W  statistics (RX_CTRL_STATS_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; rx_enable=0, rx_soft_reset=0, strobes=0, counters=0.
//  Config regs reset to: sync_tmo=320, hdr_tmo=400, data_tmo=0xFFFF, holdoff=16.
//  States: IDLE=0, SYNC=1, HDR=2, DATA=3, RECOVER=4, HOLDOFF=5.
//  IDLE: rx_enable=enable&~tx_busy. short_preamble_detected -> SYNC, tmo counter cleared.
//  SYNC: long_preamble_detected -> HDR. Counter reaches sync_tmo -> RECOVER.
//  HDR: legacy_sig_stb -> DATA. Counter reaches hdr_tmo -> RECOVER.
//  DATA: fcs_out_strobe -> IDLE, pkt_done_stb=1. Counter reaches data_tmo -> RECOVER.
//  Counter: +1 per sample_in_strobe, saturates at all-ones. Cleared on every state entry.
//    Compare is >= against the live register value, so lowering a timeout mid-packet
//    fires on the next sample strobe.
//  RECOVER: rx_soft_reset=1 for exactly RST_CYCLES cycles, rx_enable=0. Then goes to HOLDOFF
//    if tx_busy, else IDLE. pkt_abort_stb is pulsed on entry.
//  HOLDOFF: rx_enable=0. Counter is held at 0 while tx_busy. After tx_busy falls, waits
//    holdoff samples, then goes to IDLE.
//  tx_busy rising in SYNC/HDR/DATA -> RECOVER (abort). In IDLE -> HOLDOFF with no reset
//    pulse and no abort strobe.
//  Priority within one cycle: fcs_out_strobe/progress event > timeout > tx_busy abort.
//    Progress wins over timeout in the same cycle.
//  enable=0 in any state -> IDLE next cycle. Any in-flight RECOVER pulse is truncated.
//    No strobes are generated.
//  Registered-output latency: every output changes 1 cycle after the causing input.
//  Config addresses: SR_RX_SYNC_TMO=20, SR_RX_HDR_TMO=21, SR_RX_DATA_TMO=22, SR_RX_HOLDOFF=23.
//    Each uses data[TMO_W-1:0]. Writes are accepted in any state. Unknown addresses are ignored.
// CONFIGURATION
//  RX_CTRL_STATS_EN defined: the three CNT_W counters are implemented.
//    On pkt_done_stb, pkt_ok_cnt (fcs_ok=1) or pkt_bad_cnt (fcs_ok=0) increments.
//    pkt_tmo_cnt increments on timeout aborts only; TX aborts are not counted.
//    Counters wrap at 2^CNT_W. Cleared by reset, or by a write to SR_RX_STATS_CLR=24.
//  RX_CTRL_STATS_EN undefined: the counter outputs are tied to 0 and no counter logic exists.
// STRUCTURE
//  common_params.v: state encodings S_RXC_*, SR_RX_* addresses, config reset defaults.
//  One sub-module: rx_ctrl_cfg (register decode + timeout regs + stats clear strobe).
//  FSM, counter and stats stay in the top module.
// TESTING
//  1 Short->long (50 samples)->SIGNAL (80)->FCS ok: states 1,2,3,0. pkt_done_stb once. ok_cnt=1.
//  2 Short preamble only, sync_tmo=320: RECOVER after 320 strobes.
//    rx_soft_reset high exactly 4 clk. pkt_abort_stb=1. tmo_cnt=1. Back to IDLE.
//  3 tx_busy high during DATA for 100 samples, holdoff=16: abort + reset pulse, HOLDOFF.
//    rx_enable=0 until 16 strobes after tx_busy falls.
//  4 fcs_out_strobe on the same cycle data_tmo is reached: pkt_done_stb=1, no abort, no reset.
//  5 Write hdr_tmo=10 while in HDR with counter=40: RECOVER on next sample strobe.
//  6 enable dropped mid-RECOVER: rx_soft_reset falls next cycle, IDLE, rx_enable=0, no strobes.

Source files
------------

// File: rtl/openofdm_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : openofdm_rx_ctrl_pkg
//  Description : Shared encodings for the dot11 receive sequencer. Holds the
//                FSM state encoding, the config register addresses and the
//                reset values of the timeout registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package openofdm_rx_ctrl_pkg;

    // Receive sequencer states (values are visible on ctrl_state)
    typedef enum logic [2:0] {
        S_RXC_IDLE    = 3'd0,
        S_RXC_SYNC    = 3'd1,
        S_RXC_HDR     = 3'd2,
        S_RXC_DATA    = 3'd3,
        S_RXC_RECOVER = 3'd4,
        S_RXC_HOLDOFF = 3'd5
    } rxc_state_t;

    // Config register addresses on the set_stb/set_addr/set_data bus
    localparam logic [7:0] SR_RX_SYNC_TMO  = 8'd20;
    localparam logic [7:0] SR_RX_HDR_TMO   = 8'd21;
    localparam logic [7:0] SR_RX_DATA_TMO  = 8'd22;
    localparam logic [7:0] SR_RX_HOLDOFF   = 8'd23;
    localparam logic [7:0] SR_RX_STATS_CLR = 8'd24;

    // Config register reset values, in sample strobes
    localparam int RXC_SYNC_TMO_DEF = 320;
    localparam int RXC_HDR_TMO_DEF  = 400;
    localparam int RXC_DATA_TMO_DEF = 65535;
    localparam int RXC_HOLDOFF_DEF  = 16;

endpackage : openofdm_rx_ctrl_pkg
`default_nettype wire

// File: rtl/openofdm_rx_ctrl_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : openofdm_rx_ctrl_cfg
//  Description : Config register decode for the receive sequencer. Holds the
//                sync/header/data timeouts and the holdoff length, and
//                produces a one-cycle statistics-clear strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module openofdm_rx_ctrl_cfg
    import openofdm_rx_ctrl_pkg::*;
#(
    parameter int TMO_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [TMO_W-1:0] sync_tmo_o,
    output logic [TMO_W-1:0] hdr_tmo_o,
    output logic [TMO_W-1:0] data_tmo_o,
    output logic [TMO_W-1:0] holdoff_o,
    output logic             stats_clr_o
);

    logic [TMO_W-1:0] sync_tmo_q;
    logic [TMO_W-1:0] hdr_tmo_q;
    logic [TMO_W-1:0] data_tmo_q;
    logic [TMO_W-1:0] holdoff_q;
    logic             stats_clr_q;

    // Only the low TMO_W bits of a write carry a value
    logic unused_cfg;
    assign unused_cfg = &{1'b0, set_data};

    // Register writes; unknown addresses fall through untouched
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_tmo_q  <= TMO_W'(RXC_SYNC_TMO_DEF);
            hdr_tmo_q   <= TMO_W'(RXC_HDR_TMO_DEF);
            data_tmo_q  <= TMO_W'(RXC_DATA_TMO_DEF);
            holdoff_q   <= TMO_W'(RXC_HOLDOFF_DEF);
            stats_clr_q <= 1'b0;
        end else begin
            stats_clr_q <= 1'b0;
            if (set_stb) begin
                case (set_addr)
                    SR_RX_SYNC_TMO:  sync_tmo_q  <= set_data[TMO_W-1:0];
                    SR_RX_HDR_TMO:   hdr_tmo_q   <= set_data[TMO_W-1:0];
                    SR_RX_DATA_TMO:  data_tmo_q  <= set_data[TMO_W-1:0];
                    SR_RX_HOLDOFF:   holdoff_q   <= set_data[TMO_W-1:0];
                    SR_RX_STATS_CLR: stats_clr_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign sync_tmo_o  = sync_tmo_q;
    assign hdr_tmo_o   = hdr_tmo_q;
    assign data_tmo_o  = data_tmo_q;
    assign holdoff_o   = holdoff_q;
    assign stats_clr_o = stats_clr_q;

endmodule : openofdm_rx_ctrl_cfg
`default_nettype wire

// File: rtl/openofdm_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : openofdm_rx_ctrl
//  Description : Sequencer/watchdog for the dot11 receive pipeline. Tracks
//                preamble -> SIGNAL -> FCS, aborts stalled receptions on
//                sample-count timeouts, blanks RX while the local TX is busy
//                and drives dot11.enable plus a soft-reset pulse.
//  Options     : RX_CTRL_STATS_EN - implements the ok/bad/timeout counters;
//                when undefined those outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module openofdm_rx_ctrl
    import openofdm_rx_ctrl_pkg::*;
#(
    parameter int TMO_W      = 16,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic             sample_in_strobe,
    input  logic             tx_busy,
    input  logic             short_preamble_detected,
    input  logic             long_preamble_detected,
    input  logic             legacy_sig_stb,
    input  logic             fcs_out_strobe,
    input  logic             fcs_ok,
    output logic             rx_enable,
    output logic             rx_soft_reset,
    output logic [2:0]       ctrl_state,
    output logic             pkt_done_stb,
    output logic             pkt_abort_stb,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_bad_cnt,
    output logic [CNT_W-1:0] pkt_tmo_cnt
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    logic [TMO_W-1:0] sync_tmo, hdr_tmo, data_tmo, holdoff;
    logic             stats_clr;

    rxc_state_t       state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic             rx_enable_q, rx_enable_d;
    logic             soft_rst_q, soft_rst_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             tmo_abort;
    logic             sync_hit, hdr_hit, data_hit, hold_done;

    openofdm_rx_ctrl_cfg #(
        .TMO_W (TMO_W)
    ) u_cfg (
        .clock       (clock),
        .reset       (reset),
        .set_stb     (set_stb),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .sync_tmo_o  (sync_tmo),
        .hdr_tmo_o   (hdr_tmo),
        .data_tmo_o  (data_tmo),
        .holdoff_o   (holdoff),
        .stats_clr_o (stats_clr)
    );

    // Next state, counters and registered-output values
    always_comb begin
        state_d   = state_q;
        tmo_abort = 1'b0;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // Timeouts are evaluated on a sample strobe against the live register
        sync_hit  = sample_in_strobe && (cnt_inc >= sync_tmo);
        hdr_hit   = sample_in_strobe && (cnt_inc >= hdr_tmo);
        data_hit  = sample_in_strobe && (cnt_inc >= data_tmo);
        hold_done = !tx_busy && ((holdoff == '0) ||
                                 (sample_in_strobe && (cnt_inc >= holdoff)));

        case (state_q)
            S_RXC_IDLE: begin
                if (short_preamble_detected) state_d = S_RXC_SYNC;
                else if (tx_busy)            state_d = S_RXC_HOLDOFF;
            end
            S_RXC_SYNC: begin
                if (long_preamble_detected) state_d = S_RXC_HDR;
                else if (sync_hit) begin
                    state_d   = S_RXC_RECOVER;
                    tmo_abort = 1'b1;
                end else if (tx_busy)       state_d = S_RXC_RECOVER;
            end
            S_RXC_HDR: begin
                if (legacy_sig_stb) state_d = S_RXC_DATA;
                else if (hdr_hit) begin
                    state_d   = S_RXC_RECOVER;
                    tmo_abort = 1'b1;
                end else if (tx_busy) state_d = S_RXC_RECOVER;
            end
            S_RXC_DATA: begin
                if (fcs_out_strobe) state_d = S_RXC_IDLE;
                else if (data_hit) begin
                    state_d   = S_RXC_RECOVER;
                    tmo_abort = 1'b1;
                end else if (tx_busy) state_d = S_RXC_RECOVER;
            end
            S_RXC_RECOVER: begin
                if (rcnt_q == RC_W'(RST_CYCLES - 1))
                    state_d = tx_busy ? S_RXC_HOLDOFF : S_RXC_IDLE;
            end
            S_RXC_HOLDOFF: begin
                if (hold_done) state_d = S_RXC_IDLE;
            end
            default: state_d = S_RXC_IDLE;
        endcase

        // Global disable overrides everything and suppresses all strobes
        if (!enable) begin
            state_d   = S_RXC_IDLE;
            tmo_abort = 1'b0;
        end

        if (state_d != state_q)
            cnt_d = '0;
        else if ((state_q == S_RXC_HOLDOFF) && tx_busy)
            cnt_d = '0;
        else if (sample_in_strobe)
            cnt_d = cnt_inc;
        else
            cnt_d = cnt_q;

        rcnt_d = ((state_q == S_RXC_RECOVER) && (state_d == S_RXC_RECOVER)) ?
                 rcnt_q + 1'b1 : '0;

        rx_enable_d = (state_d == S_RXC_SYNC) || (state_d == S_RXC_HDR) ||
                      (state_d == S_RXC_DATA) ||
                      ((state_d == S_RXC_IDLE) && enable && !tx_busy);
        soft_rst_d  = (state_d == S_RXC_RECOVER);
        done_d      = enable && (state_q == S_RXC_DATA) && fcs_out_strobe;
        abort_d     = (state_d == S_RXC_RECOVER) && (state_q != S_RXC_RECOVER);
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RXC_IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            rx_enable_q <= 1'b0;
            soft_rst_q  <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            rx_enable_q <= rx_enable_d;
            soft_rst_q  <= soft_rst_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign rx_enable     = rx_enable_q;
    assign rx_soft_reset = soft_rst_q;
    assign ctrl_state    = state_q;
    assign pkt_done_stb  = done_q;
    assign pkt_abort_stb = abort_q;

`ifdef RX_CTRL_STATS_EN
    logic [CNT_W-1:0] ok_cnt_q, bad_cnt_q, tmo_cnt_q;

    // Packet statistics; a clear request takes priority over a same-cycle count
    always_ff @(posedge clock) begin
        if (reset || stats_clr) begin
            ok_cnt_q  <= '0;
            bad_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (done_d && fcs_ok)  ok_cnt_q  <= ok_cnt_q + 1'b1;
            if (done_d && !fcs_ok) bad_cnt_q <= bad_cnt_q + 1'b1;
            if (tmo_abort)         tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_bad_cnt = bad_cnt_q;
    assign pkt_tmo_cnt = tmo_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, stats_clr, fcs_ok, tmo_abort};
    assign pkt_ok_cnt   = '0;
    assign pkt_bad_cnt  = '0;
    assign pkt_tmo_cnt  = '0;
`endif

endmodule : openofdm_rx_ctrl
`default_nettype wire
